// File: rtl/veselov_hns_pipe_if.sv
// Handshake bundle for the HNS pipe: digest in on one side, normalised metrics out on the other.
interface veselov_hns_pipe_if #(
   parameter int HASH_W = 256,
   parameter int CH     = 4
);
   logic [HASH_W-1:0] hash_in;
   logic              in_valid;
   logic              in_ready;
   logic [CH*32-1:0]  norm_out;
   logic [31:0]       energy;
   logic [31:0]       coherence;
   logic              out_valid;
   logic              out_ready;

   modport master (output hash_in, in_valid, out_ready,
                   input  in_ready, norm_out, energy, coherence, out_valid);
   modport slave  (input  hash_in, in_valid, out_ready,
                   output in_ready, norm_out, energy, coherence, out_valid);
endinterface

// File: rtl/veselov_hns_pipe.sv
// Slices a digest into CH channels, reduces each mod MOD and normalises to FRAC-bit
// fixed point with one shared serial restoring divider, then emits energy/coherence.
module veselov_hns_pipe #(
   parameter int HASH_W = 256,
   parameter int CH     = 4,
   parameter int CH_W   = 32,
   parameter int FRAC   = 16,
   parameter int MOD    = 1000000
) (
   input  logic              clk,
   input  logic              reset_n,
   veselov_hns_pipe_if.slave bus,
   input  logic              clear_phase,
   output logic [15:0]       frame_cnt,
   output logic              busy,
   output logic [2:0]        state
);
   localparam int CW = $clog2((CH_W > FRAC) ? CH_W : FRAC) + 1;
   localparam int KW = (CH > 1) ? $clog2(CH) : 1;
   localparam logic [CH_W:0] MODV = (CH_W+1)'(MOD);
   localparam logic [31:0]   ONE  = 32'd1 << FRAC;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0, S_MOD = 3'd1, S_DIV = 3'd2, S_ACC = 3'd3, S_DONE = 3'd4
   } st_t;

   st_t                       st, st_nx;
   logic [CH*CH_W-1:0]        dig;
   logic [CH_W-1:0]           sh;
   logic [CH_W:0]             rem, trial, rem_nx;
   logic                      ge;
   logic [FRAC-1:0]           quo, quo_nx;
   logic [CW-1:0]             cnt;
   logic [KW-1:0]             k;
   logic [CH-1:0][FRAC-1:0]   nw;
   logic [FRAC-1:0]           prev;
   logic [CH*32-1:0]          norm_q;
   logic [31:0]               energy_q, coh_q, en_c, coh_c, d, d2, sat;
   logic                      out_valid_q;
   logic                      last_mod, last_div, hs;
   logic                      unused_hi;

   assign unused_hi     = ^(bus.hash_in >> (CH*CH_W));
   assign bus.in_ready  = (st == S_IDLE);
   assign bus.norm_out  = norm_q;
   assign bus.energy    = energy_q;
   assign bus.coherence = coh_q;
   assign bus.out_valid = out_valid_q;
   assign busy          = (st != S_IDLE);
   assign state         = st;

   assign last_mod = (cnt == CW'(CH_W-1));
   assign last_div = (cnt == CW'(FRAC-1));
   assign hs       = out_valid_q && bus.out_ready;

   // One restoring step: MOD feeds dividend bits MSB-first, DIV feeds zeros (r*2^FRAC).
   assign trial  = {rem[CH_W-1:0], (st == S_MOD) ? sh[CH_W-1] : 1'b0};
   assign ge     = (trial >= MODV);
   assign rem_nx = ge ? (trial - MODV) : trial;
   assign quo_nx = FRAC'({quo, ge});

   always_comb begin
      en_c = '0;
      for (int i = 0; i < CH; i++) en_c = en_c + (32'(nw[i]) >> i);
      d     = 32'((nw[CH-1] >= prev) ? (nw[CH-1] - prev) : (prev - nw[CH-1]));
      d2    = d << 1;
      sat   = (d2 > ONE) ? ONE : d2;
      coh_c = ONE - sat;
   end

   always_comb begin
      st_nx = st;
      case (st)
         S_IDLE: if (bus.in_valid) st_nx = S_MOD;
         S_MOD:  if (last_mod) st_nx = S_DIV;
         S_DIV:  if (last_div) st_nx = (k == KW'(CH-1)) ? S_ACC : S_MOD;
         S_ACC:  st_nx = S_DONE;
         S_DONE: if (hs) st_nx = S_IDLE;
         default: st_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         st          <= S_IDLE;
         dig         <= '0;
         sh          <= '0;
         rem         <= '0;
         quo         <= '0;
         cnt         <= '0;
         k           <= '0;
         nw          <= '0;
         prev        <= '0;
         norm_q      <= '0;
         energy_q    <= '0;
         coh_q       <= '0;
         out_valid_q <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         st <= st_nx;
         // A clear beats the ACC update; coh_c above still sees the old prev.
         if (clear_phase)      prev <= '0;
         else if (st == S_ACC) prev <= nw[CH-1];
         case (st)
            S_IDLE: if (bus.in_valid) begin
               dig <= bus.hash_in[CH*CH_W-1:0];
               sh  <= bus.hash_in[CH_W-1:0];
               rem <= '0;
               cnt <= '0;
               k   <= '0;
            end
            S_MOD: begin
               sh  <= sh << 1;
               rem <= rem_nx;
               cnt <= last_mod ? '0 : cnt + 1'b1;
            end
            S_DIV: begin
               rem <= rem_nx;
               quo <= quo_nx;
               cnt <= last_div ? '0 : cnt + 1'b1;
               if (last_div) begin
                  nw[k] <= quo_nx;
                  k     <= k + 1'b1;
                  sh    <= CH_W'(dig >> (CH_W * (int'(k) + 1)));
                  rem   <= '0;
               end
            end
            S_ACC: begin
               for (int i = 0; i < CH; i++) norm_q[i*32 +: 32] <= 32'(nw[i]);
               energy_q <= en_c;
               coh_q    <= coh_c;
            end
            S_DONE: begin
               if (hs) begin
                  out_valid_q <= 1'b0;
                  frame_cnt   <= frame_cnt + 16'd1;
               end else begin
                  out_valid_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule
